// File: rtl/mask_vga_pkg.sv
// Shared VGA mask types and default 640x480 timing.
// Used by mask_generation_VGA (row type) and by the mask row serializer.
package mask_vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_TOTAL_DEF  = 800;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_TOTAL_DEF  = 525;

  // Raster counters are 10 bits; totals above 1024 cannot be represented.
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned CNT_MAX = 1024;

  // One mask row; index 0 is the leftmost pixel.
  typedef logic [0:H_ACTIVE_DEF-1] mask_row_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ser_state_e;

endpackage

// File: rtl/vga_raster_counter.sv
// VGA raster position generator: h/v counters with compare-and-clear wrap,
// line-end and next-line-visible flags, active-region and frame-start flags.
// Counters are held at 0 while run_i is low.
module vga_raster_counter
  import mask_vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_TOTAL  = H_TOTAL_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_TOTAL  = V_TOTAL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en_i,
  input  logic             run_i,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             line_end_o,
  output logic             next_vis_o,
  output logic             pix_active_o,
  output logic             frame_start_o
);

  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_timing
    $error("vga_raster_counter: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic [CNT_W-1:0] v_next;

  // Next raster position and the flags derived from the current one.
  always_comb begin
    v_next        = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + ONE;
    line_end_o    = run_i && (h_cnt_q == H_LAST);
    next_vis_o    = 32'(v_next) < V_ACTIVE;
    pix_active_o  = run_i && (32'(h_cnt_q) < H_ACTIVE) && (32'(v_cnt_q) < V_ACTIVE);
    frame_start_o = run_i && clk_en_i && (h_cnt_q == '0) && (v_cnt_q == '0);
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    if (!run_i) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (clk_en_i) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = v_next;
      end else begin
        h_cnt_d = h_cnt_q + ONE;
      end
    end
  end

  // Raster position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o = h_cnt_q;
  assign v_cnt_o = v_cnt_q;

endmodule

// File: rtl/mask_row_serializer.sv
// Double-buffered mask row serializer: accepts 640-bit rows over valid/ready
// into a shadow buffer, moves them to the active buffer at line boundaries
// and shifts one bit out per visible pixel of the internal VGA raster.
// Optional build macro MASK_UNDERRUN_CNT_EN adds a saturating underrun_cnt.
module mask_row_serializer
  import mask_vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_TOTAL  = H_TOTAL_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_TOTAL  = V_TOTAL_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic [0:H_ACTIVE-1] mask_in,
  input  logic               mask_valid,
  output logic               mask_ready,
  output logic               pix_mask,
  output logic               pix_active,
  output logic [CNT_W-1:0]   h_cnt,
  output logic [CNT_W-1:0]   v_cnt,
  output logic               frame_start,
  output logic               underrun
`ifdef MASK_UNDERRUN_CNT_EN
  ,
  output logic [15:0]        underrun_cnt
`endif
);

  ser_state_e          state_q, state_d;
  logic [0:H_ACTIVE-1] shadow_q, shadow_d;
  logic [0:H_ACTIVE-1] active_q, active_d;
  logic                shadow_full_q, shadow_full_d;

  logic run;
  logic line_end;
  logic next_vis;
  logic line_load;
  logic accept;

  assign run = (state_q == RUN);

  vga_raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_TOTAL  (H_TOTAL),
    .V_ACTIVE (V_ACTIVE),
    .V_TOTAL  (V_TOTAL)
  ) u_raster (
    .clk           (clk),
    .rst           (rst),
    .clk_en_i      (clk_en),
    .run_i         (run),
    .h_cnt_o       (h_cnt),
    .v_cnt_o       (v_cnt),
    .line_end_o    (line_end),
    .next_vis_o    (next_vis),
    .pix_active_o  (pix_active),
    .frame_start_o (frame_start)
  );

  // Buffer handoff: the first load out of IDLE, then one load at the end of
  // every line that precedes a visible line. A full shadow may be refilled in
  // the same cycle it drains, so ready is raised on that cycle.
  always_comb begin
    line_load  = clk_en && ((!run && shadow_full_q) || (run && line_end && next_vis));
    mask_ready = !shadow_full_q || line_load;
    accept     = mask_valid && mask_ready && clk_en;
    underrun   = line_load && !shadow_full_q && !mask_valid;
    pix_mask   = pix_active && active_q[0];

    state_d       = state_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    active_d      = active_q;
    if (line_load) begin
      state_d = RUN;
      if (shadow_full_q) begin
        active_d      = shadow_q;
        shadow_full_d = accept;
        if (accept) begin
          shadow_d = mask_in;
        end
      end else if (mask_valid) begin
        // Bypass: a row arriving exactly at the boundary goes straight to active.
        active_d = mask_in;
      end else begin
        // No row available: the next line is fully masked off.
        active_d = '0;
      end
    end else if (clk_en) begin
      if (accept) begin
        shadow_d      = mask_in;
        shadow_full_d = 1'b1;
      end
      if (pix_active) begin
        // Next pixel moves into bit 0, zero-filled from the right.
        active_d = active_q << 1;
      end
    end
  end

  // Control state and row buffers; reset discards both buffers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      shadow_q      <= '0;
      active_q      <= '0;
      shadow_full_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      shadow_full_q <= shadow_full_d;
    end
  end

`ifdef MASK_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Saturating underrun event counter; only reset clears it.
  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  // Underrun counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_cnt = ucnt_q;
`endif

endmodule
